// File: rtl/decoder_addr_sequencer_pkg.sv
// Shared definitions for the decoder address sequencer: state encoding, scan modes,
// address range and the addr/dir next-value function.
package decoder_seq_pkg;

  localparam int unsigned ADDR_W = 3;
  localparam logic [ADDR_W-1:0] ADDR_MAX = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_SWEEP = 2'd2
  } state_e;

  localparam logic [1:0] MODE_UP    = 2'b00;
  localparam logic [1:0] MODE_DOWN  = 2'b01;
  localparam logic [1:0] MODE_PING  = 2'b10;
  localparam logic [1:0] MODE_SWEEP = 2'b11;

  // Returns {dir_up, addr}. Ping-pong re-derives direction at the endpoints so a
  // stale dir inherited from another mode can never step past 0 or 7.
  function automatic logic [ADDR_W:0] next_pos(input logic [ADDR_W-1:0] addr,
                                               input logic              dir_up,
                                               input logic [1:0]        mode);
    logic              up;
    logic [ADDR_W-1:0] nxt;
    up  = dir_up;
    nxt = addr;
    case (mode)
      MODE_DOWN: nxt = addr - 1'b1;
      MODE_PING: begin
        if (addr == ADDR_MAX) up = 1'b0;
        else if (addr == '0)  up = 1'b1;
        nxt = up ? addr + 1'b1 : addr - 1'b1;
        if (nxt == ADDR_MAX) up = 1'b0;
        else if (nxt == '0)  up = 1'b1;
      end
      default:   nxt = addr + 1'b1;
    endcase
    return {up, nxt};
  endfunction

endpackage

// File: rtl/decoder_addr_sequencer_scan_prescaler.sv
// Slot prescaler: counts 0..CLK_DIV-1 while run is high, flags the last cycle of each slot.
module scan_prescaler #(
  parameter int unsigned CLK_DIV = 50_000,
  parameter int unsigned CNT_W   = 16
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic clr,
  input  logic run,
  output logic slot_end
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    slot_end = run && !clr && (cnt_q == CNT_LAST);
    cnt_d    = cnt_q;
    if (clr)      cnt_d = '0;
    else if (run) cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) cnt_q <= '0;
    else            cnt_q <= cnt_d;
  end

endmodule

// File: rtl/decoder_addr_sequencer.sv
// Scan sequencer producing the 3-bit address for the active-low 3-to-8 decoder:
// continuous up/down/ping-pong scan, single-shot sweep and manual step.
module decoder_addr_sequencer
  import decoder_seq_pkg::*;
#(
  parameter int unsigned CLK_DIV = 50_000,
  parameter int unsigned CNT_W   = 16
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              en,
  input  logic [1:0]        mode,
  input  logic              start,
  input  logic              step,
  output logic [ADDR_W-1:0] addr,
  output logic              addr_valid,
  output logic              tick,
  output logic              busy,
  output logic              done
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              dir_q, dir_d;
  logic              tick_q, tick_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic              valid_q, valid_d;
  logic              run, slot_end;

  // Prescaler runs only while the current cycle stays in RUN/SWEEP; an exiting RUN clears it.
  assign run = (state_q == ST_SWEEP) ||
               ((state_q == ST_RUN) && en && (mode != MODE_SWEEP));

  scan_prescaler #(
    .CLK_DIV (CLK_DIV),
    .CNT_W   (CNT_W)
  ) u_prescaler (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .clr       (!run),
    .run       (run),
    .slot_end  (slot_end)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    dir_d   = dir_q;
    tick_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && (mode == MODE_SWEEP)) begin
          state_d = ST_SWEEP;
          addr_d  = '0;
          tick_d  = 1'b1;
        end else if (en && (mode != MODE_SWEEP)) begin
          state_d = ST_RUN;
        end else if (step) begin
          {dir_d, addr_d} = next_pos(addr_q, dir_q,
                                     (mode == MODE_SWEEP) ? MODE_UP : mode);
          tick_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (!run) begin
          state_d = ST_IDLE;
        end else if (slot_end) begin
          {dir_d, addr_d} = next_pos(addr_q, dir_q, mode);
          tick_d = 1'b1;
        end
      end
      ST_SWEEP: begin
        if (slot_end) begin
          if (addr_q == ADDR_MAX) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            addr_d = addr_q + 1'b1;
            tick_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    valid_d = (state_d != ST_IDLE);
    busy_d  = (state_d == ST_SWEEP);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      dir_q   <= 1'b1;
      tick_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      dir_q   <= dir_d;
      tick_q  <= tick_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
    end
  end

  assign addr       = addr_q;
  assign addr_valid = valid_q;
  assign tick       = tick_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_decoder_addr_sequencer.sv
// Directed bench for decoder_addr_sequencer with CLK_DIV=4, plus a random phase against a
// behavioural reference model.
module tb_decoder_addr_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en, start, step;
  logic [1:0] mode;
  logic [2:0] addr;
  logic       addr_valid, tick, busy, done;
  logic [6:0] obs;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  decoder_addr_sequencer #(
    .CLK_DIV (4),
    .CNT_W   (4)
  ) dut (
    .sys_clk    (clk),
    .sys_rst_n  (rst_n),
    .en         (en),
    .mode       (mode),
    .start      (start),
    .step       (step),
    .addr       (addr),
    .addr_valid (addr_valid),
    .tick       (tick),
    .busy       (busy),
    .done       (done)
  );

  assign obs = {addr, addr_valid, tick, busy, done};

  function automatic logic [6:0] pk(input int a, input logic v, input logic t,
                                    input logic b, input logic d);
    logic [2:0] a3;
    a3 = a[2:0];
    return {a3, v, t, b, d};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_reset();
    logic [6:0] exp;
    rst_n = 1'b0; en = 1'b0; mode = 2'b00; start = 1'b0; step = 1'b0;
    repeat (3) cyc();
    tests++;
    if (obs !== 7'd0) begin
      fails++;
      $display("FAIL reset_held: got %b want %b", obs, 7'd0);
    end
    rst_n = 1'b1;
    exp = pk(0, 0, 0, 0, 0);
    for (int i = 0; i < 12; i++) begin
      cyc();
      tests++;
      if (obs !== exp) begin
        fails++;
        $display("FAIL reset_idle[%0d]: got %b want %b", i, obs, exp);
      end
    end
  endtask

  task automatic test_up();
    int prev, nxt;
    en = 1'b1; mode = 2'b00;
    cyc();
    tests++;
    if (obs !== pk(0, 1, 0, 0, 0)) begin
      fails++;
      $display("FAIL up_entry: got %b want %b", obs, pk(0, 1, 0, 0, 0));
    end
    prev = 0;
    for (int i = 1; i <= 13; i++) begin
      nxt = i % 8;
      repeat (3) begin
        cyc();
        tests++;
        if (obs !== pk(prev, 1, 0, 0, 0)) begin
          fails++;
          $display("FAIL up_dwell[%0d]: got %b want %b", i, obs, pk(prev, 1, 0, 0, 0));
        end
      end
      cyc();
      tests++;
      if (obs !== pk(nxt, 1, 1, 0, 0)) begin
        fails++;
        $display("FAIL up_adv[%0d]: got %b want %b", i, obs, pk(nxt, 1, 1, 0, 0));
      end
      prev = nxt;
    end
    en = 1'b0;
    for (int i = 0; i < 9; i++) begin
      cyc();
      tests++;
      if (obs !== pk(5, 0, 0, 0, 0)) begin
        fails++;
        $display("FAIL up_hold[%0d]: got %b want %b", i, obs, pk(5, 0, 0, 0, 0));
      end
    end
  endtask

  task automatic test_ping();
    int seq [15] = '{1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1};
    int prev;
    do_reset();
    en = 1'b1; mode = 2'b10;
    cyc();
    prev = 0;
    for (int i = 0; i < 15; i++) begin
      repeat (3) begin
        cyc();
        tests++;
        if (obs !== pk(prev, 1, 0, 0, 0)) begin
          fails++;
          $display("FAIL ping_dwell[%0d]: got %b want %b", i, obs, pk(prev, 1, 0, 0, 0));
        end
      end
      cyc();
      tests++;
      if (obs !== pk(seq[i], 1, 1, 0, 0)) begin
        fails++;
        $display("FAIL ping_adv[%0d]: got %b want %b", i, obs, pk(seq[i], 1, 1, 0, 0));
      end
      prev = seq[i];
    end
    en = 1'b0;
    cyc();
    tests++;
    if (obs !== pk(1, 0, 0, 0, 0)) begin
      fails++;
      $display("FAIL ping_exit: got %b want %b", obs, pk(1, 0, 0, 0, 0));
    end
  endtask

  task automatic test_sweep();
    mode = 2'b11; start = 1'b1;
    cyc();
    start = 1'b0;
    tests++;
    if (obs !== pk(0, 1, 1, 1, 0)) begin
      fails++;
      $display("FAIL sweep_entry: got %b want %b", obs, pk(0, 1, 1, 1, 0));
    end
    for (int k = 0; k < 8; k++) begin
      if (k == 3) begin
        en = 1'b1; mode = 2'b00; step = 1'b1; start = 1'b1;
      end
      if (k == 4) begin
        step = 1'b0; start = 1'b0;
      end
      repeat (3) begin
        cyc();
        tests++;
        if (obs !== pk(k, 1, 0, 1, 0)) begin
          fails++;
          $display("FAIL sweep_dwell[%0d]: got %b want %b", k, obs, pk(k, 1, 0, 1, 0));
        end
      end
      cyc();
      tests++;
      if (k < 7) begin
        if (obs !== pk(k + 1, 1, 1, 1, 0)) begin
          fails++;
          $display("FAIL sweep_adv[%0d]: got %b want %b", k, obs, pk(k + 1, 1, 1, 1, 0));
        end
      end else if (obs !== pk(7, 0, 0, 0, 1)) begin
        fails++;
        $display("FAIL sweep_done: got %b want %b", obs, pk(7, 0, 0, 0, 1));
      end
    end
    en = 1'b0; mode = 2'b11;
    cyc();
    tests++;
    if (obs !== pk(7, 0, 0, 0, 0)) begin
      fails++;
      $display("FAIL sweep_after: got %b want %b", obs, pk(7, 0, 0, 0, 0));
    end
  endtask

  task automatic test_back_to_back();
    int exp_a [3] = '{7, 6, 5};
    do_reset();
    mode = 2'b01; step = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      tests++;
      if (obs !== pk(exp_a[i], 0, 1, 0, 0)) begin
        fails++;
        $display("FAIL step_b2b[%0d]: got %b want %b", i, obs, pk(exp_a[i], 0, 1, 0, 0));
      end
    end
    step = 1'b0;
    cyc();
    tests++;
    if (obs !== pk(5, 0, 0, 0, 0)) begin
      fails++;
      $display("FAIL step_idle: got %b want %b", obs, pk(5, 0, 0, 0, 0));
    end
    mode = 2'b11; step = 1'b1;
    cyc();
    step = 1'b0;
    tests++;
    if (obs !== pk(6, 0, 1, 0, 0)) begin
      fails++;
      $display("FAIL step_mode11: got %b want %b", obs, pk(6, 0, 1, 0, 0));
    end
    mode = 2'b00; en = 1'b1; step = 1'b1;
    repeat (4) begin
      cyc();
      tests++;
      if (obs !== pk(6, 1, 0, 0, 0)) begin
        fails++;
        $display("FAIL step_in_run: got %b want %b", obs, pk(6, 1, 0, 0, 0));
      end
    end
    cyc();
    tests++;
    if (obs !== pk(7, 1, 1, 0, 0)) begin
      fails++;
      $display("FAIL step_run_adv: got %b want %b", obs, pk(7, 1, 1, 0, 0));
    end
    step = 1'b0; en = 1'b0;
    cyc();
  endtask

  task automatic test_reset_mid_sweep();
    mode = 2'b11; start = 1'b1;
    cyc();
    start = 1'b0;
    repeat (12) cyc();
    tests++;
    if (obs !== pk(3, 1, 1, 1, 0)) begin
      fails++;
      $display("FAIL rst_sweep_pre: got %b want %b", obs, pk(3, 1, 1, 1, 0));
    end
    #3;
    rst_n = 1'b0;
    #1;
    tests++;
    if (obs !== pk(0, 0, 0, 0, 0)) begin
      fails++;
      $display("FAIL rst_sweep_async: got %b want %b", obs, pk(0, 0, 0, 0, 0));
    end
    cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      cyc();
      tests++;
      if (obs !== pk(0, 0, 0, 0, 0)) begin
        fails++;
        $display("FAIL rst_sweep_after[%0d]: got %b want %b", i, obs, pk(0, 0, 0, 0, 0));
      end
    end
  endtask

  // Behavioural reference: state 0 idle, 1 run, 2 sweep.
  int         m_state, m_cnt;
  logic [2:0] m_addr;
  logic       m_up, m_tick, m_done;

  task automatic model_adv(input logic [1:0] md);
    if (md == 2'b01) begin
      m_addr = m_addr - 3'd1;
    end else if (md == 2'b10) begin
      if (m_addr == 3'd7) m_up = 1'b0;
      if (m_addr == 3'd0) m_up = 1'b1;
      m_addr = m_up ? m_addr + 3'd1 : m_addr - 3'd1;
      if (m_addr == 3'd7) m_up = 1'b0;
      if (m_addr == 3'd0) m_up = 1'b1;
    end else begin
      m_addr = m_addr + 3'd1;
    end
  endtask

  task automatic model_step();
    m_tick = 1'b0;
    m_done = 1'b0;
    if (m_state == 0) begin
      m_cnt = 0;
      if (start && mode == 2'b11) begin
        m_state = 2; m_addr = 3'd0; m_tick = 1'b1;
      end else if (en && mode != 2'b11) begin
        m_state = 1;
      end else if (step) begin
        model_adv(mode == 2'b11 ? 2'b00 : mode);
        m_tick = 1'b1;
      end
    end else if (m_state == 1) begin
      if (!en || mode == 2'b11) begin
        m_state = 0; m_cnt = 0;
      end else if (m_cnt == 3) begin
        m_cnt = 0; model_adv(mode); m_tick = 1'b1;
      end else begin
        m_cnt++;
      end
    end else begin
      if (m_cnt == 3) begin
        m_cnt = 0;
        if (m_addr == 3'd7) begin
          m_state = 0; m_done = 1'b1;
        end else begin
          m_addr = m_addr + 3'd1; m_tick = 1'b1;
        end
      end else begin
        m_cnt++;
      end
    end
  endtask

  task automatic test_random();
    logic [6:0] exp;
    en = 1'b0; mode = 2'b00; start = 1'b0; step = 1'b0;
    do_reset();
    m_state = 0; m_cnt = 0; m_addr = 3'd0; m_up = 1'b1;
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 19) == 0) en = ~en;
      if ($urandom_range(0, 24) == 0) mode = 2'($urandom_range(0, 3));
      start = ($urandom_range(0, 14) == 0);
      step  = ($urandom_range(0, 5) == 0);
      model_step();
      cyc();
      exp = {m_addr, m_state != 0, m_tick, m_state == 2, m_done};
      tests++;
      if (obs !== exp) begin
        fails++;
        $display("FAIL random[%0d]: got %b want %b", i, obs, exp);
      end
    end
    en = 1'b0; start = 1'b0; step = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_up();
    test_ping();
    test_sweep();
    test_back_to_back();
    test_reset_mid_sweep();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
